// File: rtl/rle_zero_decoder_if.sv
// rle_zero_decoder_if: token input stream, word output stream and status of the zero-run decoder
interface rle_zero_decoder_if #(
  parameter int DATA_WIDTH = 16
) ();
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH:0]   in_token;
  logic                  in_last;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_last;
  logic                  busy;
  modport master (
    output in_valid, in_token, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_last, busy
  );
  modport slave (
    input  in_valid, in_token, in_last, out_ready,
    output in_ready, out_valid, out_data, out_last, busy
  );
endinterface

// File: rtl/rle_zero_decoder.sv
// rle_zero_decoder: expands literal and zero-run tokens into one data word per handshake
module rle_zero_decoder #(
  parameter int DATA_WIDTH = 16,
  parameter int RUN_BITS   = 6
) (
  input logic               clk,
  input logic               arst_n_in,
  rle_zero_decoder_if.slave bus
);
  typedef enum logic [1:0] {EMPTY, LIT, RUN} state_t;
  state_t                r_state;
  logic [RUN_BITS-1:0]   r_run_cnt;
  logic [DATA_WIDTH-1:0] r_data;
  logic                  r_last_pend;
  logic                  w_out_valid;
  logic                  w_done;
  logic                  w_out_fire;
  logic                  w_in_ready;
  logic                  w_in_fire;
  logic                  w_is_run;
  assign w_out_valid = r_state != EMPTY;
  assign w_done      = (r_state == LIT) | ((r_state == RUN) & (r_run_cnt == '0));
  assign w_out_fire  = w_out_valid & bus.out_ready;
  // a finishing word frees the slot in the same cycle, so tokens stream without bubbles
  assign w_in_ready  = (r_state == EMPTY) | (w_out_fire & w_done);
  assign w_in_fire   = bus.in_valid & w_in_ready;
  assign w_is_run    = bus.in_token[DATA_WIDTH];
  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = w_out_valid;
  assign bus.out_data  = r_data;
  assign bus.out_last  = r_last_pend & w_done & w_out_valid;
  assign bus.busy      = w_out_valid;
  always_ff @(posedge clk or negedge arst_n_in) begin
    if (!arst_n_in) begin
      r_state     <= EMPTY;
      r_run_cnt   <= '0;
      r_data      <= '0;
      r_last_pend <= 1'b0;
    end else if (w_in_fire) begin
      r_state     <= w_is_run ? RUN : LIT;
      r_data      <= w_is_run ? '0 : bus.in_token[DATA_WIDTH-1:0];
      r_run_cnt   <= w_is_run ? bus.in_token[RUN_BITS-1:0] : '0;
      r_last_pend <= bus.in_last;
    end else if (w_out_fire) begin
      if (w_done) r_state <= EMPTY;
      else r_run_cnt <= r_run_cnt - 1'b1;
    end
  end
endmodule

// File: tb/tb_rle_zero_decoder.sv
// tb_rle_zero_decoder: directed scenarios plus randomized token streams against a queue-based expansion model
module tb_rle_zero_decoder;
  localparam int DW = 16;
  localparam int RB = 6;
  logic clk = 1'b0;
  logic arst_n = 1'b0;
  int n_cmp = 0;
  int n_err = 0;
  always #5 clk = ~clk;
  rle_zero_decoder_if #(.DATA_WIDTH(DW)) bus ();
  rle_zero_decoder #(.DATA_WIDTH(DW), .RUN_BITS(RB)) dut (
    .clk(clk),
    .arst_n_in(arst_n),
    .bus(bus.slave)
  );
  function automatic logic [DW:0] lit(input logic [DW-1:0] v);
    return {1'b0, v};
  endfunction
  function automatic logic [DW:0] run(input logic [RB-1:0] f);
    return {1'b1, {(DW-RB){1'b0}}, f};
  endfunction
  task automatic drive(input logic v, input logic [DW:0] tok, input logic last, input logic ordy);
    @(negedge clk);
    bus.in_valid  = v;
    bus.in_token  = tok;
    bus.in_last   = last;
    bus.out_ready = ordy;
    #1;
  endtask
  task automatic test_reset();
    arst_n = 1'b0;
    for (int k = 0; k < 3; k++) begin
      if (k == 2) begin
        @(negedge clk);
        arst_n = 1'b1;
      end
      drive(1'b0, '0, 1'b0, 1'b0);
      n_cmp++;
      if ({bus.out_valid, bus.out_data, bus.out_last, bus.busy, bus.in_ready} !== {1'b0, 16'h0, 1'b0, 1'b0, 1'b1}) begin
        n_err++;
        $display("FAIL reset[%0d] {valid,data,last,busy,in_ready} got %b/%h/%b/%b/%b want 0/0000/0/0/1",
                 k, bus.out_valid, bus.out_data, bus.out_last, bus.busy, bus.in_ready);
      end
    end
  endtask
  task automatic test_literals();
    logic exp_v;
    for (int k = 0; k < 5; k++) begin
      drive(k < 3, lit(16'(k + 1)), 1'b0, 1'b1);
      exp_v = (k >= 1) && (k <= 3);
      n_cmp++;
      if ({bus.in_ready, bus.out_valid} !== {1'b1, exp_v}) begin
        n_err++;
        $display("FAIL literals[%0d] {in_ready,out_valid} got %b%b want 1%b", k, bus.in_ready, bus.out_valid, exp_v);
      end
      if (exp_v) begin
        n_cmp++;
        if (bus.out_data !== 16'(k)) begin
          n_err++;
          $display("FAIL literals[%0d] out_data got %h want %h", k, bus.out_data, 16'(k));
        end
      end
    end
  endtask
  task automatic test_run();
    int stalls = 0;
    logic [DW-1:0] exp_d;
    drive(1'b1, run(6'd3), 1'b0, 1'b1);
    n_cmp++;
    if (bus.in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL run accept in_ready got %b want 1", bus.in_ready);
    end
    for (int k = 1; k <= 5; k++) begin
      drive(k <= 4, lit(16'hBEEF), 1'b0, 1'b1);
      if (bus.in_ready !== 1'b1) stalls++;
      exp_d = (k <= 4) ? 16'h0 : 16'hBEEF;
      n_cmp++;
      if ({bus.out_valid, bus.out_data, bus.in_ready} !== {1'b1, exp_d, k >= 4}) begin
        n_err++;
        $display("FAIL run[%0d] {valid,data,in_ready} got %b/%h/%b want 1/%h/%b",
                 k, bus.out_valid, bus.out_data, bus.in_ready, exp_d, k >= 4);
      end
    end
    n_cmp++;
    if (stalls != 3) begin
      n_err++;
      $display("FAIL run stall cycles got %0d want 3", stalls);
    end
    drive(1'b0, '0, 1'b0, 1'b1);
    n_cmp++;
    if (bus.out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL run drained out_valid got %b want 0", bus.out_valid);
    end
  endtask
  task automatic test_max_run();
    int words = 0, lasts = 0, last_at = -1, nz = 0;
    drive(1'b1, run(6'd63), 1'b1, 1'b1);
    for (int k = 0; k < 70; k++) begin
      drive(1'b0, '0, 1'b0, 1'b1);
      if (bus.out_valid === 1'b1) begin
        words++;
        if (bus.out_data !== 16'h0) nz++;
        if (bus.out_last === 1'b1) begin
          lasts++;
          last_at = words;
        end
      end
    end
    n_cmp++;
    if (words != 64 || nz != 0) begin
      n_err++;
      $display("FAIL max_run words/nonzero got %0d/%0d want 64/0", words, nz);
    end
    n_cmp++;
    if (lasts != 1 || last_at != 64) begin
      n_err++;
      $display("FAIL max_run out_last count/position got %0d/%0d want 1/64", lasts, last_at);
    end
    n_cmp++;
    if (bus.busy !== 1'b0) begin
      n_err++;
      $display("FAIL max_run busy after got %b want 0", bus.busy);
    end
  endtask
  task automatic test_stall();
    drive(1'b1, lit(16'h1234), 1'b0, 1'b0);
    for (int k = 0; k < 5; k++) begin
      drive(1'b1, lit(16'h5555), 1'b0, 1'b0);
      n_cmp++;
      if ({bus.out_valid, bus.out_data, bus.in_ready} !== {1'b1, 16'h1234, 1'b0}) begin
        n_err++;
        $display("FAIL stall[%0d] {valid,data,in_ready} got %b/%h/%b want 1/1234/0",
                 k, bus.out_valid, bus.out_data, bus.in_ready);
      end
    end
    drive(1'b1, lit(16'h5555), 1'b0, 1'b1);
    n_cmp++;
    if ({bus.in_ready, bus.out_data} !== {1'b1, 16'h1234}) begin
      n_err++;
      $display("FAIL stall release {in_ready,data} got %b/%h want 1/1234", bus.in_ready, bus.out_data);
    end
    drive(1'b0, '0, 1'b0, 1'b1);
    n_cmp++;
    if ({bus.out_valid, bus.out_data} !== {1'b1, 16'h5555}) begin
      n_err++;
      $display("FAIL stall next {valid,data} got %b/%h want 1/5555", bus.out_valid, bus.out_data);
    end
    drive(1'b0, '0, 1'b0, 1'b1);
  endtask
  task automatic test_reset_mid_run();
    int seen = 0;
    drive(1'b1, run(6'd9), 1'b0, 1'b1);
    for (int k = 0; k < 2; k++) begin
      drive(1'b0, '0, 1'b0, 1'b1);
      n_cmp++;
      if ({bus.out_valid, bus.out_data} !== {1'b1, 16'h0}) begin
        n_err++;
        $display("FAIL midreset zero[%0d] {valid,data} got %b/%h want 1/0000", k, bus.out_valid, bus.out_data);
      end
    end
    #1 arst_n = 1'b0;
    #1;
    n_cmp++;
    if (bus.out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL midreset async out_valid got %b want 0", bus.out_valid);
    end
    repeat (2) @(negedge clk);
    arst_n = 1'b1;
    drive(1'b0, '0, 1'b0, 1'b1);
    n_cmp++;
    if ({bus.in_ready, bus.busy} !== 2'b10) begin
      n_err++;
      $display("FAIL midreset after {in_ready,busy} got %b%b want 10", bus.in_ready, bus.busy);
    end
    for (int k = 0; k < 12; k++) begin
      drive(1'b0, '0, 1'b0, 1'b1);
      if (bus.out_valid !== 1'b0) seen++;
    end
    n_cmp++;
    if (seen != 0) begin
      n_err++;
      $display("FAIL midreset resumed words got %0d want 0", seen);
    end
  endtask
  task automatic test_random();
    logic [DW:0] exp_q[$];
    logic [DW:0] cur_tok, e;
    logic [DW-1:0] prev_data;
    logic cur_last, have, v, prev_hold;
    int sent = 0, got = 0, pushed = 0, cycles = 0, len, field;
    have = 1'b0;
    prev_hold = 1'b0;
    prev_data = '0;
    cur_tok = '0;
    cur_last = 1'b0;
    while ((sent < 10000 || exp_q.size() > 0) && cycles < 90000) begin
      if (!have && sent < 10000) begin
        field = ($urandom_range(0, 19) == 0) ? 63 : int'($urandom_range(0, 7));
        cur_tok = ($urandom_range(0, 4) == 0) ? {1'b1, (DW-RB)'($urandom), RB'(field)}
                : {1'b0, ($urandom_range(0, 9) == 0) ? 16'h0 : 16'($urandom)};
        cur_last = $urandom_range(0, 7) == 0;
        have = 1'b1;
      end
      v = have && ($urandom_range(0, 3) != 0);
      drive(v, v ? cur_tok : (DW+1)'($urandom), v ? cur_last : 1'($urandom), $urandom_range(0, 3) != 0);
      cycles++;
      if (prev_hold) begin
        n_cmp++;
        if ({bus.out_valid, bus.out_data} !== {1'b1, prev_data}) begin
          n_err++;
          $display("FAIL random hold cyc %0d {valid,data} got %b/%h want 1/%h", cycles, bus.out_valid, bus.out_data, prev_data);
        end
      end
      prev_hold = bus.out_valid && !bus.out_ready;
      prev_data = bus.out_data;
      if (bus.out_valid && bus.out_ready) begin
        got++;
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL random extra word cyc %0d got %h want none", cycles, bus.out_data);
        end else begin
          e = exp_q.pop_front();
          if ({bus.out_last, bus.out_data} !== e) begin
            n_err++;
            $display("FAIL random word %0d {last,data} got %b/%h want %b/%h", got, bus.out_last, bus.out_data, e[DW], e[DW-1:0]);
          end
        end
      end
      if (bus.in_valid && bus.in_ready) begin
        len = cur_tok[DW] ? int'(cur_tok[RB-1:0]) + 1 : 1;
        for (int i = 0; i < len; i++)
          exp_q.push_back({cur_last && (i == len - 1), cur_tok[DW] ? 16'h0 : cur_tok[DW-1:0]});
        pushed += len;
        sent++;
        have = 1'b0;
      end
    end
    n_cmp++;
    if (sent != 10000 || exp_q.size() != 0) begin
      n_err++;
      $display("FAIL random completion tokens/pending got %0d/%0d want 10000/0 after %0d cycles", sent, exp_q.size(), cycles);
    end
    n_cmp++;
    if (got != pushed) begin
      n_err++;
      $display("FAIL random word count got %0d want %0d", got, pushed);
    end
    drive(1'b0, '0, 1'b0, 1'b1);
    n_cmp++;
    if (bus.busy !== 1'b0) begin
      n_err++;
      $display("FAIL random busy at end got %b want 0", bus.busy);
    end
  endtask
  initial begin
    bus.in_valid  = 1'b0;
    bus.in_token  = '0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b0;
    test_reset();
    test_literals();
    test_run();
    test_max_run();
    test_stall();
    test_reset_mid_run();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
